// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared state encoding and bus constants for the LCD write path.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    localparam int   LCD_BUS_W   = 8;
    localparam logic LCD_DC_CMD  = 1'b0;
    localparam logic LCD_DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        RST_LOW  = 3'd0,
        RST_WAIT = 3'd1,
        IDLE     = 3'd2,
        WR_LO    = 3'd3,
        WR_HI    = 3'd4
    } lcd_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_wr.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_wr
// Purpose  : 8080-style panel write driver: hardware-reset sequence, then one
//            timed lcd_wr strobe per byte accepted over valid/ready.
// Revision : 1.0
// ============================================================================
module lcd_bus_wr
    import lcd_pkg::*;
#(
    parameter int RST_LOW_CYC  = 240,
    parameter int RST_WAIT_CYC = 2880000,
    parameter int WR_LOW_CYC   = 1,
    parameter int WR_HIGH_CYC  = 1
) (
    input  logic                 mco,
    input  logic                 res_n,
    input  logic                 re_init,
    input  logic                 in_valid,
    input  logic                 in_dc,
    input  logic [LCD_BUS_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 init_done,
    output logic                 busy,
    output logic [LCD_BUS_W-1:0] lcd_data,
    output logic                 lcd_wr,
    output logic                 lcd_dc,
    output logic                 lcd_rst
);

    localparam int CNT_W = $clog2(max4(RST_LOW_CYC, RST_WAIT_CYC, WR_LOW_CYC, WR_HIGH_CYC)) + 1;

    localparam logic [CNT_W-1:0] C_RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] C_WR_LOW_LAST   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);

    lcd_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lcd_rst_q, lcd_rst_d;
    logic                 lcd_wr_q, lcd_wr_d;
    logic                 lcd_dc_q, lcd_dc_d;
    logic [LCD_BUS_W-1:0] lcd_data_q, lcd_data_d;
    logic                 in_ready_q, in_ready_d;
    logic                 init_done_q, init_done_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge mco or negedge res_n) begin
        if (!res_n) begin
            state_q     <= RST_LOW;
            cnt_q       <= '0;
            lcd_rst_q   <= 1'b0;
            lcd_wr_q    <= 1'b1;
            lcd_dc_q    <= LCD_DC_CMD;
            lcd_data_q  <= '0;
            in_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_rst_q   <= lcd_rst_d;
            lcd_wr_q    <= lcd_wr_d;
            lcd_dc_q    <= lcd_dc_d;
            lcd_data_q  <= lcd_data_d;
            in_ready_q  <= in_ready_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lcd_rst_d   = lcd_rst_q;
        lcd_wr_d    = lcd_wr_q;
        lcd_dc_d    = lcd_dc_q;
        lcd_data_d  = lcd_data_q;
        in_ready_d  = in_ready_q;
        init_done_d = init_done_q;

        // re_init overrides everything, including a write in flight
        if (re_init) begin
            state_d     = RST_LOW;
            lcd_wr_d    = 1'b1;
            lcd_rst_d   = 1'b0;
            init_done_d = 1'b0;
            in_ready_d  = 1'b0;
        end else begin
            case (state_q)
                RST_LOW: begin
                    if (cnt_q == C_RST_LOW_LAST) begin
                        lcd_rst_d = 1'b1;
                        state_d   = RST_WAIT;
                    end
                end
                RST_WAIT: begin
                    if (cnt_q == C_RST_WAIT_LAST) begin
                        init_done_d = 1'b1;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        lcd_data_d = in_data;
                        lcd_dc_d   = in_dc;
                        lcd_wr_d   = 1'b0;
                        in_ready_d = 1'b0;
                        state_d    = WR_LO;
                    end
                end
                WR_LO: begin
                    if (cnt_q == C_WR_LOW_LAST) begin
                        lcd_wr_d = 1'b1;
                        state_d  = WR_HI;
                    end
                end
                WR_HI: begin
                    if (cnt_q == C_WR_HIGH_LAST) begin
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = RST_LOW;
                end
            endcase
        end

        // Counter restarts on every state change (and re_init), so it never wraps
        if (re_init || (state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign lcd_rst   = lcd_rst_q;
    assign lcd_wr    = lcd_wr_q;
    assign lcd_dc    = lcd_dc_q;
    assign lcd_data  = lcd_data_q;
    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
